// File: rtl/reg_file_if.sv
// Register file access bus: two combinational read ports and one synchronous write port.
interface reg_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] rn1;
  logic [ADDR_WIDTH-1:0] rn2;
  logic [ADDR_WIDTH-1:0] wn;
  logic                  write;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] out1;
  logic [DATA_WIDTH-1:0] out2;

  modport master (output rn1, rn2, wn, write, wd, input out1, out2);
  modport slave  (input rn1, rn2, wn, write, wd, output out1, out2);
endinterface

// File: rtl/reg_file.sv
// 2**ADDR_WIDTH x DATA_WIDTH register file, register 0 hardwired to zero,
// two async read ports, one write port, synchronous active-high clear.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);
  localparam int NREGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [NREGS];

  // Reset wins over a coincident write; index 0 is never loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (bus.write && (bus.wn != '0)) begin
      mem[bus.wn] <= bus.wd;
    end
  end

  // No bypass: a write becomes visible only after the edge that stores it.
  assign bus.out1 = (bus.rn1 == '0) ? '0 : mem[bus.rn1];
  assign bus.out2 = (bus.rn2 == '0) ? '0 : mem[bus.rn2];
endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  reg_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.write = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.rn1 = AW'(i); bus.rn2 = AW'(31 - i);
      #1;
      checks++;
      if (bus.out1 !== 32'h0) begin
        errors++; $display("FAIL reset_out1 idx=%0d got=%h exp=%h", i, bus.out1, 32'h0);
      end
      checks++;
      if (bus.out2 !== 32'h0) begin
        errors++; $display("FAIL reset_out2 idx=%0d got=%h exp=%h", 31 - i, bus.out2, 32'h0);
      end
    end
  endtask

  task automatic test_write_sweep();
    for (int n = 1; n < 32; n++) begin
      bus.write = 1'b1; bus.wn = AW'(n); bus.wd = 32'(4 * n);
      tick();
    end
    bus.write = 1'b0;
    for (int n = 1; n < 32; n++) begin
      bus.rn1 = AW'(n - 1); bus.rn2 = AW'(n);
      #1;
      checks++;
      if (bus.out1 !== 32'(4 * (n - 1))) begin
        errors++; $display("FAIL sweep_out1 rn1=%0d got=%h exp=%h", n - 1, bus.out1, 32'(4 * (n - 1)));
      end
      checks++;
      if (bus.out2 !== 32'(4 * n)) begin
        errors++; $display("FAIL sweep_out2 rn2=%0d got=%h exp=%h", n, bus.out2, 32'(4 * n));
      end
    end
  endtask

  task automatic test_reg0();
    bus.write = 1'b1; bus.wn = '0; bus.wd = 32'hFFFF_FFFF;
    tick();
    bus.write = 1'b0; bus.rn1 = '0; bus.rn2 = 5'd1;
    #1;
    checks++;
    if (bus.out1 !== 32'h0) begin
      errors++; $display("FAIL reg0_write got=%h exp=%h", bus.out1, 32'h0);
    end
    checks++;
    if (bus.out2 !== 32'h4) begin
      errors++; $display("FAIL reg0_side_effect got=%h exp=%h", bus.out2, 32'h4);
    end
  endtask

  task automatic test_read_during_write();
    bus.rn1 = 5'd3; bus.rn2 = 5'd3; bus.wn = 5'd3; bus.wd = 32'hDEAD_BEEF; bus.write = 1'b1;
    #1;
    checks++;
    if (bus.out1 !== 32'h0000_000C) begin
      errors++; $display("FAIL rdw_before got=%h exp=%h", bus.out1, 32'h0000_000C);
    end
    tick();
    bus.write = 1'b0;
    checks++;
    if (bus.out1 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rdw_after got=%h exp=%h", bus.out1, 32'hDEAD_BEEF);
    end
    checks++;
    if (bus.out2 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rdw_same_index got=%h exp=%h", bus.out2, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_no_write();
    bus.write = 1'b0; bus.wn = 5'd7; bus.wd = 32'h1234_5678;
    repeat (3) tick();
    // A write pulse that is withdrawn before the edge must leave no trace.
    bus.wn = 5'd10; bus.wd = 32'h5555_AAAA; bus.write = 1'b1;
    #2;
    bus.write = 1'b0;
    tick();
    bus.rn1 = 5'd7; bus.rn2 = 5'd10;
    #1;
    checks++;
    if (bus.out1 !== 32'h0000_001C) begin
      errors++; $display("FAIL no_write_r7 got=%h exp=%h", bus.out1, 32'h0000_001C);
    end
    checks++;
    if (bus.out2 !== 32'h0000_0028) begin
      errors++; $display("FAIL glitch_write_r10 got=%h exp=%h", bus.out2, 32'h0000_0028);
    end
  endtask

  task automatic test_back_to_back();
    bus.write = 1'b1; bus.wn = 5'd20; bus.wd = 32'h8000_0001;
    tick();
    bus.wn = 5'd21; bus.wd = 32'h7FFF_FFFE;
    tick();
    bus.write = 1'b0; bus.rn1 = 5'd20; bus.rn2 = 5'd21;
    #1;
    checks++;
    if (bus.out1 !== 32'h8000_0001) begin
      errors++; $display("FAIL b2b_r20 got=%h exp=%h", bus.out1, 32'h8000_0001);
    end
    checks++;
    if (bus.out2 !== 32'h7FFF_FFFE) begin
      errors++; $display("FAIL b2b_r21 got=%h exp=%h", bus.out2, 32'h7FFF_FFFE);
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; bus.write = 1'b1; bus.wn = 5'd9; bus.wd = 32'hA5A5_A5A5;
    tick();
    rst = 1'b0; bus.write = 1'b0; bus.rn1 = 5'd9; bus.rn2 = 5'd5;
    #1;
    checks++;
    if (bus.out1 !== 32'h0) begin
      errors++; $display("FAIL rst_prio_r9 got=%h exp=%h", bus.out1, 32'h0);
    end
    checks++;
    if (bus.out2 !== 32'h0) begin
      errors++; $display("FAIL rst_clear_r5 got=%h exp=%h", bus.out2, 32'h0);
    end
    bus.rn1 = 5'd20; bus.rn2 = 5'd31;
    #1;
    checks++;
    if (bus.out1 !== 32'h0) begin
      errors++; $display("FAIL rst_clear_r20 got=%h exp=%h", bus.out1, 32'h0);
    end
    checks++;
    if (bus.out2 !== 32'h0) begin
      errors++; $display("FAIL rst_clear_r31 got=%h exp=%h", bus.out2, 32'h0);
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b0;
    bus.rn1 = '0; bus.rn2 = '0; bus.wn = '0; bus.write = 1'b0; bus.wd = '0;
    @(negedge clk);
    test_reset();
    test_write_sweep();
    test_reg0();
    test_read_during_write();
    test_no_write();
    test_back_to_back();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each register and of the data ports.
REQ-002 Parameter ADDR_WIDTH, default 5, register index width; register count is 2**ADDR_WIDTH (32).
REQ-003 Clock  input  1  clock; all state updates occur on its rising edge.
REQ-004 Reset  input  1  reset, synchronous and active-high, sampled on the rising edge of Clock.
REQ-005 Rn1  input  ADDR_WIDTH  read port 1 register index.
REQ-006 Rn2  input  ADDR_WIDTH  read port 2 register index.
REQ-007 Wn  input  ADDR_WIDTH  write port register index.
REQ-008 Write  input  1  write enable, active-high.
REQ-009 Wd  input  DATA_WIDTH  write data.
REQ-010 Out1  output  DATA_WIDTH  contents of register Rn1.
REQ-011 Out2  output  DATA_WIDTH  contents of register Rn2.

Function
REQ-012 The block SHALL hold 2**ADDR_WIDTH registers of DATA_WIDTH bits, indexed 0..2**ADDR_WIDTH-1.
REQ-013 Out1 SHALL combinationally reflect register[Rn1], with zero clock latency, and change whenever Rn1 or the addressed register changes.
REQ-014 Out2 SHALL behave identically for Rn2, independently of port 1; Rn1 == Rn2 SHALL give identical outputs.
REQ-015 On a rising Clock edge with Reset=0, Write=1 and Wn != 0, register[Wn] SHALL be loaded with Wd.
REQ-016 With Write=0, no register SHALL change.
REQ-017 Register 0 SHALL read as all zeros at all times; writes with Wn=0 SHALL be ignored.
REQ-018 Read-during-write (Rn1 or Rn2 == Wn, Write=1): the output SHALL show the old value before the edge and the new value Wd immediately after it; there is no write-to-read bypass.
REQ-019 Wd, Wn and Write SHALL only be sampled at the rising edge; changes between edges SHALL have no effect on stored state.
REQ-020 Write data SHALL be stored unmodified at full DATA_WIDTH, with no sign or zero extension or truncation.
REQ-021 There SHALL be no internal pipeline, handshake or busy state; a write can occur every cycle.

Reset
REQ-022 On a rising Clock edge with Reset=1, all registers SHALL be cleared to 0, so Out1 = Out2 = 0 for every index afterwards.
REQ-023 Reset SHALL have priority over Write; a write presented in a reset cycle SHALL be discarded.
REQ-024 Reset SHALL not affect the combinational read path other than through cleared contents; register contents before the first reset are undefined except register 0, which reads 0.
REQ-025 A reset asserted between previous writes SHALL clear every previously written value at that edge.

Verification
REQ-026 Reset=1 for one edge, then Write=0, sweep Rn1 and Rn2 over 0..31 -> Out1 = Out2 = 0 for every index.
REQ-027 Write Wd = 4*n to Wn = n for n = 1..31 on successive edges, then read Rn1 = n-1 and Rn2 = n -> Out1 = 4*(n-1) and Out2 = 4*n (for example Rn2=5 gives 0x14).
REQ-028 Write=1, Wn=0, Wd=0xFFFFFFFF, then Rn1=0 -> Out1 = 0.
REQ-029 Rn1 = Wn = 3, register 3 holding 0x0000000C, Wd=0xDEADBEEF, Write=1 -> Out1 = 0x0000000C before the edge and 0xDEADBEEF after it.
REQ-030 Write=0, Wn=7, Wd=0x12345678 held for several edges -> register 7 keeps its prior value.
REQ-031 Reset=1 and Write=1 in the same cycle, with Wn=9 and Wd=0xA5A5A5A5 -> after the edge register 9 reads 0.
